signal_sequencer: RTL and testbench

SIGNAL_SEQUENCER -- requirements
Module: signal_sequencer

---
 rtl/signal_sequencer.sv | 160 ++++++++++++++++
 tb/tb_signal_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/signal_sequencer.sv
// Burst pulse generator: programmable high/low lengths, pulses per burst,
// optional continuous repetition separated by a gap.
module signal_sequencer #(
    parameter int CNT_W = 16,
    parameter int NUM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_low,
    input  logic [CNT_W-1:0] cfg_gap,
    input  logic [NUM_W-1:0] cfg_num,
    input  logic             cfg_cont,
    input  logic             start,
    input  logic             stop,
    output logic             signal,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] pulse_idx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_GAP
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_high;
    logic [CNT_W-1:0] r_low;
    logic [CNT_W-1:0] r_gap;
    logic [NUM_W-1:0] r_num;
    logic             r_cont;
    logic             r_signal;
    logic             r_busy;
    logic             r_done;
    logic [NUM_W-1:0] r_pulse_idx;

    logic             w_load;
    logic [CNT_W-1:0] w_high_sel;
    logic [NUM_W-1:0] w_num_sel;
    logic [CNT_W-1:0] w_high_len;
    logic [CNT_W-1:0] w_low_len;
    logic [NUM_W-1:0] w_idx_inc;
    logic             w_last;
    logic             w_cnt_end;

    assign cfg_ready  = (r_state == S_IDLE);
    assign w_load     = cfg_valid && cfg_ready;

    // A start coinciding with a config write must see the new values.
    assign w_high_sel = w_load ? cfg_high : r_high;
    assign w_num_sel  = w_load ? cfg_num : r_num;
    assign w_high_len = (w_high_sel == '0) ? ONE : w_high_sel;
    assign w_low_len  = (r_low == '0) ? ONE : r_low;
    assign w_idx_inc  = r_pulse_idx + NUM_W'(1);
    assign w_last     = ({1'b0, r_pulse_idx} + (NUM_W+1)'(1)) >= {1'b0, r_num};
    assign w_cnt_end  = (r_cnt == ONE);

    assign signal     = r_signal;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pulse_idx  = r_pulse_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= ONE;
            r_high      <= ONE;
            r_low       <= ONE;
            r_gap       <= '0;
            r_num       <= '0;
            r_cont      <= 1'b0;
            r_signal    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pulse_idx <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_high <= cfg_high;
                r_low  <= cfg_low;
                r_gap  <= cfg_gap;
                r_num  <= cfg_num;
                r_cont <= cfg_cont;
            end
            if (r_state == S_IDLE) begin
                if (start && !stop) begin
                    if (w_num_sel != '0) begin
                        r_state     <= S_HIGH;
                        r_cnt       <= w_high_len;
                        r_signal    <= 1'b1;
                        r_busy      <= 1'b1;
                        r_pulse_idx <= '0;
                    end else begin
                        r_done <= 1'b1;
                    end
                end
            end else if (stop) begin
                r_state  <= S_IDLE;
                r_signal <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    S_HIGH: begin
                        if (w_cnt_end) begin
                            r_state  <= S_LOW;
                            r_cnt    <= w_low_len;
                            r_signal <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - ONE;
                        end
                    end
                    S_LOW: begin
                        if (!w_cnt_end) begin
                            r_cnt <= r_cnt - ONE;
                        end else if (!w_last) begin
                            r_state     <= S_HIGH;
                            r_cnt       <= w_high_len;
                            r_signal    <= 1'b1;
                            r_pulse_idx <= w_idx_inc;
                        end else if (!r_cont) begin
                            r_state     <= S_IDLE;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_pulse_idx <= w_idx_inc;
                        end else if (r_gap != '0) begin
                            r_state     <= S_GAP;
                            r_cnt       <= r_gap;
                            r_pulse_idx <= w_idx_inc;
                        end else begin
                            r_state     <= S_HIGH;
                            r_cnt       <= w_high_len;
                            r_signal    <= 1'b1;
                            r_pulse_idx <= '0;
                        end
                    end
                    S_GAP: begin
                        if (w_cnt_end) begin
                            r_state     <= S_HIGH;
                            r_cnt       <= w_high_len;
                            r_signal    <= 1'b1;
                            r_pulse_idx <= '0;
                        end else begin
                            r_cnt <= r_cnt - ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_signal_sequencer.sv
// Bench for signal_sequencer: directed table, hand-written corner sequences
// and randomized bursts against a trace-building reference model.
module tb_signal_sequencer;

    localparam int CNT_W = 16;
    localparam int NUM_W = 8;
    localparam int LIM   = 50;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_high;
    logic [CNT_W-1:0] cfg_low;
    logic [CNT_W-1:0] cfg_gap;
    logic [NUM_W-1:0] cfg_num;
    logic             cfg_cont;
    logic             start;
    logic             stop;
    logic             signal;
    logic             busy;
    logic             done;
    logic [NUM_W-1:0] pulse_idx;

    signal_sequencer #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_high(cfg_high), .cfg_low(cfg_low), .cfg_gap(cfg_gap),
        .cfg_num(cfg_num), .cfg_cont(cfg_cont),
        .start(start), .stop(stop),
        .signal(signal), .busy(busy), .done(done), .pulse_idx(pulse_idx)
    );

    always #10 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit sig;
        bit bsy;
        bit dn;
        int idx;
    } exp_t;

    exp_t exp_q[$];

    // model configuration and last pulse index
    int m_h = 1, m_l = 1, m_g = 0, m_n = 0, m_idx = 0;
    bit m_c = 1'b0;

    typedef struct {
        int h; int l; int g; int n; bit cont; bit same; int s;
        int e_busy; int e_ones; int e_done; int e_idx;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    // Expected per-cycle trace after the start edge, derived from burst rules.
    task automatic build(input int s);
        int he;
        int le;
        bit fin;
        he  = (m_h == 0) ? 1 : m_h;
        le  = (m_l == 0) ? 1 : m_l;
        fin = 1'b0;
        exp_q.delete();
        if (m_n == 0) begin
            exp_q.push_back('{1'b0, 1'b0, 1'b1, m_idx});
        end else begin
            while (!fin && exp_q.size() < LIM) begin
                for (int p = 0; p < m_n; p++) begin
                    for (int k = 0; k < he; k++) exp_q.push_back('{1'b1, 1'b1, 1'b0, p});
                    for (int k = 0; k < le; k++) exp_q.push_back('{1'b0, 1'b1, 1'b0, p});
                end
                if (!m_c) begin
                    exp_q.push_back('{1'b0, 1'b0, 1'b1, m_n});
                    fin = 1'b1;
                end else begin
                    for (int k = 0; k < m_g; k++) exp_q.push_back('{1'b0, 1'b1, 1'b0, m_n});
                end
            end
        end
        while (exp_q.size() < LIM) exp_q.push_back('{1'b0, 1'b0, 1'b0, exp_q[$].idx});
        while (exp_q.size() > LIM) void'(exp_q.pop_back());
        if (s >= 0 && s < LIM - 1 && exp_q[s].bsy)
            for (int t = s + 1; t < LIM; t++) exp_q[t] = '{1'b0, 1'b0, 1'b0, exp_q[s].idx};
        m_idx = exp_q[LIM-1].idx;
    endtask

    task automatic run(input bit load, input bit same, input int h, input int l,
                       input int g, input int n, input bit cont, input int s,
                       input bit garb, output int o_busy, output int o_ones,
                       output int o_done, output int o_idx);
        logic [31:0] act;
        logic [31:0] exv;
        if (load) begin
            cfg_high  = CNT_W'(h);
            cfg_low   = CNT_W'(l);
            cfg_gap   = CNT_W'(g);
            cfg_num   = NUM_W'(n);
            cfg_cont  = cont;
            cfg_valid = 1'b1;
            m_h = h; m_l = l; m_g = g; m_n = n; m_c = cont;
            if (!same) begin
                step();
                cfg_valid = 1'b0;
            end
        end
        start = 1'b1;
        step();
        start     = 1'b0;
        cfg_valid = 1'b0;
        build(s);
        o_busy = 0; o_ones = 0; o_done = 0; o_idx = 0;
        for (int t = 0; t < LIM; t++) begin
            act = {20'd0, signal, busy, done, cfg_ready, pulse_idx};
            exv = {20'd0, exp_q[t].sig, exp_q[t].bsy, exp_q[t].dn, !exp_q[t].bsy,
                   NUM_W'(exp_q[t].idx)};
            check($sformatf("cycle%0d{sig,busy,done,rdy,idx}", t), act, exv);
            o_busy += int'(busy);
            o_ones += int'(signal);
            o_done += int'(done);
            if (t == LIM - 1) o_idx = int'(pulse_idx);
            stop = (t == s);
            if (garb && exp_q[t].bsy && $urandom_range(0, 2) == 0) begin
                start     = 1'b1;
                cfg_valid = 1'b1;
                cfg_high  = CNT_W'($urandom_range(0, 7));
                cfg_low   = CNT_W'($urandom_range(0, 7));
                cfg_num   = NUM_W'($urandom_range(0, 7));
                cfg_gap   = CNT_W'($urandom_range(0, 7));
                cfg_cont  = 1'($urandom_range(0, 1));
            end else begin
                start     = 1'b0;
                cfg_valid = 1'b0;
            end
            step();
        end
        stop = 1'b0; start = 1'b0; cfg_valid = 1'b0;
    endtask

    vec_t vecs[8];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int ob, oo, od, oi;
        vecs[0] = '{3, 2, 0, 4, 1'b0, 1'b0, -1, 20, 12, 1, 4};
        vecs[1] = '{0, 0, 0, 2, 1'b0, 1'b0, -1, 4, 2, 1, 2};
        vecs[2] = '{1, 3, 0, 1, 1'b0, 1'b1, -1, 4, 1, 1, 1};
        vecs[3] = '{5, 1, 0, 0, 1'b0, 1'b0, -1, 0, 0, 1, 1};
        vecs[4] = '{2, 1, 4, 2, 1'b1, 1'b0, 7, 8, 4, 0, 2};
        vecs[5] = '{2, 2, 0, 1, 1'b1, 1'b1, 9, 10, 6, 0, 0};
        vecs[6] = '{1, 1, 0, 3, 1'b0, 1'b1, -1, 6, 3, 1, 3};
        vecs[7] = '{4, 1, 2, 3, 1'b1, 1'b0, 0, 1, 1, 0, 0};

        rst = 1'b1; cfg_valid = 1'b0; cfg_high = '0; cfg_low = '0; cfg_gap = '0;
        cfg_num = '0; cfg_cont = 1'b0; start = 1'b0; stop = 1'b0;
        #5;
        check("reset_signal", 32'(signal), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_idx", 32'(pulse_idx), 32'd0);
        check("reset_ready", 32'(cfg_ready), 32'd1);
        step();
        rst = 1'b0;
        step();

        // first start after reset sees the default zero pulse count
        run(1'b0, 1'b0, 0, 0, 0, 0, 1'b0, -1, 1'b0, ob, oo, od, oi);
        check("post_reset_done", 32'(od), 32'd1);
        check("post_reset_busy", 32'(ob), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run(1'b1, vecs[i].same, vecs[i].h, vecs[i].l, vecs[i].g, vecs[i].n,
                vecs[i].cont, vecs[i].s, 1'b1, ob, oo, od, oi);
            check($sformatf("vec%0d_busy_cycles", i), 32'(ob), 32'(vecs[i].e_busy));
            check($sformatf("vec%0d_high_cycles", i), 32'(oo), 32'(vecs[i].e_ones));
            check($sformatf("vec%0d_done_pulses", i), 32'(od), 32'(vecs[i].e_done));
            check($sformatf("vec%0d_final_idx", i), 32'(oi), 32'(vecs[i].e_idx));
        end

        // start and stop together while idle: nothing happens
        cfg_high = 16'd1; cfg_low = 16'd1; cfg_gap = 16'd0; cfg_num = 8'd2;
        cfg_cont = 1'b0; cfg_valid = 1'b1;
        m_h = 1; m_l = 1; m_g = 0; m_n = 2; m_c = 1'b0;
        step();
        cfg_valid = 1'b0; start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check("startstop_busy", 32'(busy), 32'd0);
        check("startstop_done", 32'(done), 32'd0);
        check("startstop_signal", 32'(signal), 32'd0);
        step();
        check("startstop_later_busy", 32'(busy), 32'd0);

        // asynchronous reset between edges during HIGH
        cfg_high = 16'd5; cfg_low = 16'd1; cfg_num = 8'd3; cfg_valid = 1'b1;
        start = 1'b1;
        step();
        cfg_valid = 1'b0; start = 1'b0;
        step();
        check("pre_rst_signal", 32'(signal), 32'd1);
        #3;
        rst = 1'b1;
        #2;
        check("async_rst_signal", 32'(signal), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_idx", 32'(pulse_idx), 32'd0);
        check("async_rst_ready", 32'(cfg_ready), 32'd1);
        #1;
        rst = 1'b0;
        m_h = 1; m_l = 1; m_g = 0; m_n = 0; m_c = 1'b0; m_idx = 0;
        run(1'b0, 1'b0, 0, 0, 0, 0, 1'b0, -1, 1'b0, ob, oo, od, oi);
        check("cfg_default_done", 32'(od), 32'd1);
        check("cfg_default_busy", 32'(ob), 32'd0);

        // randomized bursts against the model
        for (int i = 0; i < 30; i++) begin
            int h, l, g, n, s;
            bit c, sm, ld;
            h  = $urandom_range(0, 4);
            l  = $urandom_range(0, 4);
            g  = $urandom_range(0, 3);
            n  = $urandom_range(0, 4);
            c  = 1'($urandom_range(0, 1));
            sm = 1'($urandom_range(0, 1));
            ld = ($urandom_range(0, 4) != 0);
            if (ld ? c : m_c) s = $urandom_range(0, 40);
            else s = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 30) : -1;
            run(ld, sm, h, l, g, n, c, s, 1'b1, ob, oo, od, oi);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
